keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 27 ++
 rtl/key_debounce.sv | 129 ++++++++++++
 rtl/keypad_scanner.sv | 105 ++++++++++
 tb/tb_keypad_scanner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner_pkg
// Purpose : Shared geometry, debounce FSM states and frame-class encoding.
// Revision: 1.0
// ============================================================================
package keypad_scanner_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_KEY   = 2'd1,
    FC_MULTI = 2'd2
  } frame_class_e;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Purpose : Frame-level debounce FSM producing pressed / key_value / strobe.
// Revision: 1.0
// ============================================================================
module key_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic [1:0]       frame_class,
  input  logic [KEY_W-1:0] frame_code,
  output logic             pressed,
  output logic [KEY_W-1:0] key_value,
  output logic             key_strobe
);

  localparam logic [2:0] DEB = 3'(DEBOUNCE_FRAMES);

  deb_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             pressed_q, pressed_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       cnt_inc;
  logic             is_key, is_none;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    pressed_d   = pressed_q;
    key_value_d = key_value_q;
    strobe_d    = 1'b0;
    cnt_inc     = cnt_q + 3'd1;
    is_key      = (frame_class == FC_KEY);
    is_none     = (frame_class == FC_NONE);

    if (frame_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_key) begin
            cand_d = frame_code;
            cnt_d  = 3'd1;
            if (DEB == 3'd1) begin
              state_d     = ST_HELD;
              pressed_d   = 1'b1;
              key_value_d = frame_code;
              strobe_d    = 1'b1;
            end else begin
              state_d = ST_PRESS_WAIT;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (is_key && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              state_d     = ST_HELD;
              pressed_d   = 1'b1;
              key_value_d = cand_q;
              strobe_d    = 1'b1;
            end
          end else if (is_key) begin
            cand_d = frame_code;
            cnt_d  = 3'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end
        end
        // A different key or a chord while held is ignored until a release.
        ST_HELD: begin
          if (is_none) begin
            cnt_d = 3'd1;
            if (DEB == 3'd1) begin
              state_d   = ST_IDLE;
              pressed_d = 1'b0;
            end else begin
              state_d = ST_RELEASE_WAIT;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              state_d   = ST_IDLE;
              pressed_d = 1'b0;
              cnt_d     = 3'd0;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      cand_q      <= '0;
      pressed_q   <= 1'b0;
      key_value_q <= '0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      pressed_q   <= pressed_d;
      key_value_q <= key_value_d;
      strobe_q    <= strobe_d;
    end
  end

  assign pressed    = pressed_q;
  assign key_value  = key_value_q;
  assign key_strobe = strobe_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Purpose : 4x4 keypad row scanner with column sync and per-frame classifier.
// Revision: 1.0
// ============================================================================
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  col_n,
  output logic [ROWS-1:0]  row_n,
  output logic             pressed,
  output logic [KEY_W-1:0] key_value,
  output logic             key_strobe
);

  logic [COLS-1:0]  col_s1_q, col_s2_q;
  logic [3:0]       dwell_q, dwell_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       seen_q, seen_d;
  logic [KEY_W-1:0] code_q, code_d;

  logic             last_dwell, frame_end;
  logic [2:0]       nhits, sum;
  logic [1:0]       hit_col, merged_seen;
  logic [KEY_W-1:0] merged_code;
  frame_class_e     frame_class;

  always_comb begin
    last_dwell = (dwell_q == 4'(SETTLE_CYCLES - 1));
    frame_end  = last_dwell && (row_q == 2'(ROWS - 1));
    dwell_d    = last_dwell ? 4'd0 : dwell_q + 4'd1;
    row_d      = last_dwell ? row_q + 2'd1 : row_q;

    nhits   = 3'd0;
    hit_col = 2'd0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2_q[c]) begin
        nhits   = nhits + 3'd1;
        hit_col = 2'(c);
      end
    end

    // Seen-key tally saturates at 2: anything beyond one key is a chord.
    sum         = {1'b0, seen_q} + nhits;
    merged_seen = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    merged_code = (seen_q == 2'd0 && nhits == 3'd1) ? {row_q, hit_col} : code_q;

    case (merged_seen)
      2'd0:    frame_class = FC_NONE;
      2'd1:    frame_class = FC_KEY;
      default: frame_class = FC_MULTI;
    endcase

    seen_d = seen_q;
    code_d = code_q;
    if (frame_end) begin
      seen_d = 2'd0;
      code_d = '0;
    end else if (last_dwell) begin
      seen_d = merged_seen;
      code_d = merged_code;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      dwell_q  <= 4'd0;
      row_q    <= 2'd0;
      seen_q   <= 2'd0;
      code_q   <= '0;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
      dwell_q  <= dwell_d;
      row_q    <= row_d;
      seen_q   <= seen_d;
      code_q   <= code_d;
    end
  end

  assign row_n = ~(4'b0001 << row_q);

  key_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst_n),
    .frame_valid(frame_end),
    .frame_class(frame_class),
    .frame_code (merged_code),
    .pressed    (pressed),
    .key_value  (key_value),
    .key_strobe (key_strobe)
  );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scanner
// Purpose : Keypad scanner bench with a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int FRAME  = 4 * SETTLE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] key_down = '0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        pressed;
  logic [3:0]  key_value;
  logic        key_strobe;

  int vectors = 0;
  int misc = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  // Physical keypad: a held key shorts its row line onto its column line.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && key_down[4*r+c]) col_n[c] = 1'b0;
  end

  keypad_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .pressed   (pressed),
    .key_value (key_value),
    .key_strobe(key_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keys seen per frame come from a snapshot history,
  // each row being observed two cycles before its last dwell cycle.
  logic [15:0] hist [64];
  int          edges;
  int          m_state, m_cand, m_cnt;
  logic        m_pressed, m_strobe;
  logic [3:0]  m_kv;
  int          nk, kcode, fs, idx, kind;

  always @(posedge clk) begin
    if (rst_n) begin
      edges = 0; m_state = 0; m_cand = 0; m_cnt = 0;
      m_pressed = 1'b0; m_strobe = 1'b0; m_kv = 4'd0;
    end else begin
      hist[edges % 64] = key_down;
      m_strobe = 1'b0;
      if (edges % FRAME == FRAME - 1) begin
        nk = 0; kcode = 0; fs = edges - FRAME + 1;
        for (int r = 0; r < 4; r++) begin
          idx = fs + r * SETTLE + SETTLE - 3;
          for (int c = 0; c < 4; c++)
            if (hist[idx % 64][4*r+c]) begin nk++; kcode = 4*r + c; end
        end
        kind = (nk == 0) ? 0 : (nk == 1) ? 1 : 2;
        case (m_state)
          0: if (kind == 1) begin
               m_cand = kcode; m_cnt = 1;
               if (m_cnt == DEB) begin
                 m_state = 2; m_pressed = 1'b1; m_kv = 4'(m_cand); m_strobe = 1'b1;
               end else m_state = 1;
             end
          1: if (kind == 1 && kcode == m_cand) begin
               m_cnt++;
               if (m_cnt == DEB) begin
                 m_state = 2; m_pressed = 1'b1; m_kv = 4'(m_cand); m_strobe = 1'b1;
               end
             end else if (kind == 1) begin
               m_cand = kcode; m_cnt = 1;
             end else m_state = 0;
          2: if (kind == 0) begin
               m_cnt = 1;
               if (m_cnt == DEB) begin m_state = 0; m_pressed = 1'b0; end
               else m_state = 3;
             end
          default: if (kind == 0) begin
               m_cnt++;
               if (m_cnt == DEB) begin m_state = 0; m_pressed = 1'b0; end
             end else m_state = 2;
        endcase
      end
      edges++;
    end
  end

  logic [3:0] exp_row;
  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobe_cnt++;
    if (rst_n) begin
      chk("reset_row_n", row_n, 4'b1110);
      chk("reset_pressed", pressed, 1'b0);
      chk("reset_strobe", key_strobe, 1'b0);
      chk("reset_key_value", key_value, 4'd0);
    end else begin
      exp_row = 4'b1111;
      exp_row[(edges % FRAME) / SETTLE] = 1'b0;
      chk("row_n", row_n, exp_row);
      chk("pressed", pressed, m_pressed);
      chk("key_strobe", key_strobe, m_strobe);
      chk("key_value", key_value, m_kv);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pressed(input logic lvl, input int limit, input string name);
    int k;
    k = 0;
    while (pressed !== lvl && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, pressed, lvl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s0;
  logic [15:0] one;
  initial begin
    one = 16'd1;
    // Reset then idle scan
    tick(10);
    rst_n = 1'b0;
    tick(4);
    @(negedge clk); #1;
    chk("row_after_4_cycles", row_n, 4'b1101);
    chk("idle_pressed", pressed, 1'b0);
    tick(96);

    // Clean press of key 8
    s0 = strobe_cnt;
    key_down = one << 8;
    wait_pressed(1'b1, 67, "press8_latency");
    chk("press8_value", key_value, 4'd8);
    tick(100);
    chk("press8_one_strobe", strobe_cnt - s0, 1);
    key_down = '0;
    wait_pressed(1'b0, 67, "release8_latency");
    chk("release8_value_held", key_value, 4'd8);
    tick(100);

    // Bouncing key 9
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      key_down = (i % 2 == 0) ? (one << 9) : 16'd0;
      tick(5);
    end
    chk("bounce_no_strobe", strobe_cnt - s0, 0);
    key_down = one << 9;
    wait_pressed(1'b1, 67, "bounce9_latency");
    chk("bounce9_value", key_value, 4'd9);
    tick(50);
    chk("bounce9_one_strobe", strobe_cnt - s0, 1);
    key_down = '0;
    wait_pressed(1'b0, 67, "release9_latency");
    tick(20);

    // Chord 1+6, then 6 released
    key_down = (one << 1) | (one << 6);
    tick(100);
    chk("chord_not_pressed", pressed, 1'b0);
    key_down = one << 1;
    wait_pressed(1'b1, 67, "chord_then_1_latency");
    chk("chord_then_1_value", key_value, 4'd1);
    key_down = '0;
    wait_pressed(1'b0, 67, "release1_latency");
    tick(20);

    // Rollover 5 -> 15
    key_down = one << 5;
    wait_pressed(1'b1, 67, "press5_latency");
    chk("press5_value", key_value, 4'd5);
    key_down = key_down | (one << 15);
    tick(20);
    key_down = one << 15;
    tick(100);
    chk("rollover_still_pressed", pressed, 1'b1);
    chk("rollover_value_5", key_value, 4'd5);
    key_down = '0;
    wait_pressed(1'b0, 67, "rollover_release");
    tick(10);
    key_down = one << 15;
    wait_pressed(1'b1, 67, "press15_latency");
    chk("press15_value", key_value, 4'd15);
    key_down = '0;
    wait_pressed(1'b0, 67, "release15_latency");
    tick(20);

    // Reset mid-press on key 3
    key_down = one << 3;
    wait_pressed(1'b1, 67, "press3_latency");
    chk("press3_value", key_value, 4'd3);
    tick(5);
    rst_n = 1'b1;
    #1;
    chk("reset_drops_pressed", pressed, 1'b0);
    tick(1);
    rst_n = 1'b0;
    tick(40);
    chk("no_early_reaccept", pressed, 1'b0);
    wait_pressed(1'b1, 67, "reaccept3_latency");
    chk("reaccept3_value", key_value, 4'd3);
    key_down = '0;
    wait_pressed(1'b0, 67, "release3_latency");

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int sel, dur, a, b, per;
      sel = $urandom_range(0, 19);
      dur = $urandom_range(5, 90);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      if (sel == 19) begin
        rst_n = 1'b1;
        tick($urandom_range(1, 3));
        rst_n = 1'b0;
      end else if (sel < 3) begin
        key_down = '0;
        tick(dur);
      end else if (sel < 12) begin
        key_down = one << a;
        tick(dur);
      end else if (sel < 16) begin
        key_down = (one << a) | (one << b);
        tick(dur);
      end else begin
        per = $urandom_range(1, 6);
        for (int t = 0; t < dur; t += per) begin
          key_down = (key_down == 16'd0) ? (one << a) : 16'd0;
          tick(per);
        end
      end
    end
    key_down = '0;
    tick(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
`default_nettype wire
